// File: rtl/pipe_pkg.sv
// Shared constants and types for the 5-stage pipeline sequencer.
package pipe_pkg;

  localparam int unsigned NUM_STAGES = 5;

  localparam int unsigned ST_IF  = 0;
  localparam int unsigned ST_ID  = 1;
  localparam int unsigned ST_EX  = 2;
  localparam int unsigned ST_MEM = 3;
  localparam int unsigned ST_WB  = 4;

  // Encoding a stage unit loads when its stage_x bit is set (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Per-action stage_ena / stage_x patterns, bit i = stage i (IF is bit 0).
  localparam logic [NUM_STAGES-1:0] ENA_ALL     = 5'b11111;
  localparam logic [NUM_STAGES-1:0] ENA_LOADUSE = 5'b11100;
  localparam logic [NUM_STAGES-1:0] ENA_IMEM    = 5'b11110;
  localparam logic [NUM_STAGES-1:0] X_FLUSH     = 5'b00111;
  localparam logic [NUM_STAGES-1:0] X_LOADUSE   = 5'b00100;
  localparam logic [NUM_STAGES-1:0] X_IMEM      = 5'b00010;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_MEM_WAIT,
    S_IMEM_WAIT
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX load and the ID source operands.
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_valid_i,
  input  logic             id_valid_i,
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  output logic             load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // A load into x0 never creates a dependency, so rd==0 is excluded.
  always_comb begin
    rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o = ex_valid_i && id_valid_i && ex_is_load_i &&
                 (ex_rd_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage enable/bubble control, live-instruction
// tracking, and saturating stall/flush event counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             stage_clk,
  input  logic             reset_n,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             flush_pipeline,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic [4:0]       stage_ena,
  output logic [4:0]       stage_x,
  output logic [4:0]       stage_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e                  state_q, state_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [NUM_STAGES-1:0]   valid_q, valid_d;
  logic                    load_use;
  logic                    mem_stall;
  logic                    flush_req;
  logic                    stall_inc;
  logic                    flush_inc;
  logic [1:0]              cnt_inc;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_valid_i   (valid_q[ST_EX]),
    .id_valid_i   (valid_q[ST_ID]),
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .load_use_o   (load_use)
  );

  // A pending flush (caught during a data-memory freeze) acts like a live one.
  assign mem_stall = valid_q[ST_MEM] && dmem_req && !dmem_ready;
  assign flush_req = flush_pipeline || flush_pend_q;

  // State register
  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_BOOT;
    else          state_q <= state_d;
  end

  // Next-state: BOOT lasts one cycle, then the wait states follow the stall causes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_MEM_WAIT, S_IMEM_WAIT: begin
        if (mem_stall)                  state_d = S_MEM_WAIT;
        else if (flush_req || load_use) state_d = S_RUN;
        else if (!imem_ready)           state_d = S_IMEM_WAIT;
        else                            state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs: mem stall > flush > load-use > imem wait > normal advance
  always_comb begin
    stage_ena = '0;
    stage_x   = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state_q == S_BOOT) begin
      stage_x = '1;
    end else if (mem_stall) begin
      stall_inc = 1'b1;
    end else if (flush_req) begin
      stage_ena = ENA_ALL;
      stage_x   = X_FLUSH;
      flush_inc = 1'b1;
    end else if (load_use) begin
      stage_ena = ENA_LOADUSE;
      stage_x   = X_LOADUSE;
      stall_inc = 1'b1;
    end else if (!imem_ready) begin
      stage_ena = ENA_IMEM;
      stage_x   = X_IMEM;
      stall_inc = 1'b1;
    end else begin
      stage_ena = ENA_ALL;
    end
  end

  // Flush pending: set by a flush seen while frozen, cleared once applied
  always_comb begin
    flush_pend_d = 1'b0;
    if (state_q != S_BOOT && mem_stall) flush_pend_d = flush_pend_q || flush_pipeline;
  end

  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) flush_pend_q <= 1'b0;
    else          flush_pend_q <= flush_pend_d;
  end

  // Valid tracking: an enabled stage takes its predecessor's valid unless bubbled
  always_comb begin
    valid_d = valid_q;
    valid_d[ST_IF] = stage_ena[ST_IF] ? (imem_ready && !stage_x[ST_IF]) : valid_q[ST_IF];
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      valid_d[i] = stage_ena[i] ? (valid_q[i-1] && !stage_x[i]) : valid_q[i];
    end
  end

  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  assign stage_valid = valid_q;

  assign cnt_inc = {flush_inc, stall_inc};

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating increment: holds at all-ones rather than wrapping
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc[g] && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge stage_clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = g_cnt[0].cnt_q;
  assign flush_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, corner sequences, and a
// randomized run against an instruction-tag pipeline model.
module tb_pipeline_ctrl;

  localparam int unsigned REG_W = 5;

  logic             stage_clk = 1'b0;
  logic             reset_n   = 1'b0;
  logic             imem_ready, dmem_req, dmem_ready, flush_pipeline, ex_is_load;
  logic [REG_W-1:0] ex_rd, id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic [4:0]       stage_ena, stage_x, stage_valid;
  logic [15:0]      stall_cnt, flush_cnt;
  logic [4:0]       ena4, x4, valid4;
  logic [3:0]       stall4, flush4;

  int n_vec = 0;
  int n_err = 0;

  always #5 stage_clk = ~stage_clk;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(16)) dut (
    .stage_clk(stage_clk), .reset_n(reset_n), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .flush_pipeline(flush_pipeline),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .stage_ena(stage_ena),
    .stage_x(stage_x), .stage_valid(stage_valid), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut4 (
    .stage_clk(stage_clk), .reset_n(reset_n), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .flush_pipeline(flush_pipeline),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .stage_ena(ena4),
    .stage_x(x4), .stage_valid(valid4), .stall_cnt(stall4), .flush_cnt(flush4)
  );

  typedef struct {
    bit         imem, dreq, drdy, fl, ld;
    int         rd, rs1;
    bit         u1;
    logic [4:0] ena, x, vld;
    int         stall, flsh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit imem, bit dreq, bit drdy, bit fl, bit ld, int rd, int rs1,
                              bit u1, logic [4:0] ena, logic [4:0] x, logic [4:0] vld,
                              int stall, int flsh);
    vec_t v;
    v.imem = imem; v.dreq = dreq; v.drdy = drdy; v.fl = fl; v.ld = ld;
    v.rd = rd; v.rs1 = rs1; v.u1 = u1;
    v.ena = ena; v.x = x; v.vld = vld; v.stall = stall; v.flsh = flsh;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_default();
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1; flush_pipeline = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
  endtask

  // ---------------- reference model: instruction tags flowing through stages
  int          pipe[5];
  bit          m_boot, m_pend;
  int unsigned m_stall, m_flush, m_stall4, m_flush4;
  int          next_id;

  function automatic int unsigned sat_inc(int unsigned v, int unsigned mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) pipe[i] = -1;
    m_boot = 1; m_pend = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    next_id = 0;
  endtask

  // Called at the negedge: compare this cycle's outputs, then advance one edge.
  task automatic model_cycle(input int cyc);
    logic [4:0] e, xx, vv;
    bit st, fl, memst, haz;
    int np[5];
    st = 0; fl = 0;
    for (int i = 0; i < 5; i++) vv[i] = (pipe[i] >= 0);
    memst = (pipe[3] >= 0) && dmem_req && !dmem_ready;
    haz = (pipe[2] >= 0) && (pipe[1] >= 0) && ex_is_load && (int'(ex_rd) != 0) &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_boot) begin e = 5'b00000; xx = 5'b11111; end
    else if (memst) begin e = 5'b00000; xx = 5'b00000; st = 1; end
    else if (flush_pipeline || m_pend) begin e = 5'b11111; xx = 5'b00111; fl = 1; end
    else if (haz) begin e = 5'b11100; xx = 5'b00100; st = 1; end
    else if (!imem_ready) begin e = 5'b11110; xx = 5'b00010; st = 1; end
    else begin e = 5'b11111; xx = 5'b00000; end

    check($sformatf("rnd%0d_ena", cyc), 32'(stage_ena), 32'(e));
    check($sformatf("rnd%0d_x", cyc), 32'(stage_x), 32'(xx));
    check($sformatf("rnd%0d_valid", cyc), 32'(stage_valid), 32'(vv));
    check($sformatf("rnd%0d_stall", cyc), 32'(stall_cnt), 32'(m_stall));
    check($sformatf("rnd%0d_flush", cyc), 32'(flush_cnt), 32'(m_flush));
    check($sformatf("rnd%0d_stall4", cyc), 32'(stall4), 32'(m_stall4));
    check($sformatf("rnd%0d_flush4", cyc), 32'(flush4), 32'(m_flush4));

    for (int i = 1; i < 5; i++) np[i] = e[i] ? (xx[i] ? -1 : pipe[i-1]) : pipe[i];
    if (e[0]) begin
      if (xx[0] || !imem_ready) np[0] = -1;
      else begin np[0] = next_id; next_id++; end
    end else np[0] = pipe[0];
    for (int i = 0; i < 5; i++) pipe[i] = np[i];
    if (st) begin m_stall = sat_inc(m_stall, 65535); m_stall4 = sat_inc(m_stall4, 15); end
    if (fl) begin m_flush = sat_inc(m_flush, 65535); m_flush4 = sat_inc(m_flush4, 15); end
    if (m_boot) m_pend = 0;
    else if (memst) m_pend = m_pend | flush_pipeline;
    else m_pend = 0;
    m_boot = 0;
  endtask

  initial begin
    // imem,dreq,drdy,fl,ld,rd,rs1,u1,  ena,     x,       valid,   stall,flush
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b00000,5'b11111,5'b00000,0,0)); // BOOT
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00000,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00001,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00011,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00111,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b01111,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b11111,0,0));
    tbl.push_back(mk(1,0,1,0,1,5,5,1, 5'b11100,5'b00100,5'b11111,0,0)); // load-use
    tbl.push_back(mk(1,0,1,0,1,5,5,1, 5'b11111,5'b00000,5'b11011,1,0)); // one cycle only
    tbl.push_back(mk(1,0,1,0,1,0,0,1, 5'b11111,5'b00000,5'b10111,1,0)); // rd=0: no stall
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b01111,1,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 5'b00000,5'b00000,5'b11111,1,0)); // mem stall
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 5'b00000,5'b00000,5'b11111,2,0));
    tbl.push_back(mk(1,1,0,1,0,0,0,0, 5'b00000,5'b00000,5'b11111,3,0)); // flush mid-wait
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 5'b11111,5'b00111,5'b11111,4,0)); // exit applies it
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b11000,4,1));
    tbl.push_back(mk(1,0,1,1,0,0,0,0, 5'b11111,5'b00111,5'b10001,4,1)); // flush in RUN
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00000,4,2));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00001,4,2));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00011,4,2));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00111,4,2));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b01111,4,2));
    tbl.push_back(mk(1,0,1,1,1,5,5,1, 5'b11111,5'b00111,5'b11111,4,2)); // flush beats load-use
    tbl.push_back(mk(0,0,1,0,0,0,0,0, 5'b11110,5'b00010,5'b11000,4,3)); // imem wait
    tbl.push_back(mk(0,0,1,0,0,0,0,0, 5'b11110,5'b00010,5'b10000,5,3));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00000,6,3));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00001,6,3));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00011,6,3));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b00111,6,3));
    tbl.push_back(mk(1,1,0,1,0,0,0,0, 5'b00000,5'b00000,5'b01111,6,3)); // flush + stall
    tbl.push_back(mk(1,1,0,1,0,0,0,0, 5'b00000,5'b00000,5'b01111,7,3)); // second flush merges
    tbl.push_back(mk(1,1,1,0,0,0,0,0, 5'b11111,5'b00111,5'b01111,8,3));
    tbl.push_back(mk(1,0,1,0,0,0,0,0, 5'b11111,5'b00000,5'b11000,8,4));

    drive_default();
    reset_n = 1'b0;
    @(negedge stage_clk);
    check("rst_ena", 32'(stage_ena), 32'h00);
    check("rst_x", 32'(stage_x), 32'h1F);
    check("rst_valid", 32'(stage_valid), 32'h00);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    check("rst_flush", 32'(flush_cnt), 32'h0);
    @(posedge stage_clk); #1;
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      imem_ready = tbl[i].imem; dmem_req = tbl[i].dreq; dmem_ready = tbl[i].drdy;
      flush_pipeline = tbl[i].fl; ex_is_load = tbl[i].ld;
      ex_rd = 5'(tbl[i].rd); id_rs1 = 5'(tbl[i].rs1); id_use_rs1 = tbl[i].u1;
      id_rs2 = '0; id_use_rs2 = 1'b0;
      @(negedge stage_clk);
      check($sformatf("t%0d_ena", i), 32'(stage_ena), 32'(tbl[i].ena));
      check($sformatf("t%0d_x", i), 32'(stage_x), 32'(tbl[i].x));
      check($sformatf("t%0d_valid", i), 32'(stage_valid), 32'(tbl[i].vld));
      check($sformatf("t%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].stall));
      check($sformatf("t%0d_flush", i), 32'(flush_cnt), 32'(tbl[i].flsh));
      @(posedge stage_clk); #1;
    end

    // Async reset while frozen in MEM_WAIT: outputs drop without a clock edge.
    drive_default();
    repeat (3) begin @(posedge stage_clk); #1; end
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(posedge stage_clk); #1;
    @(negedge stage_clk);
    check("memwait_ena", 32'(stage_ena), 32'h00);
    check("memwait_stall", 32'(stall_cnt), 32'd9);
    #1 reset_n = 1'b0;
    #1;
    check("async_ena", 32'(stage_ena), 32'h00);
    check("async_x", 32'(stage_x), 32'h1F);
    check("async_valid", 32'(stage_valid), 32'h00);
    check("async_stall", 32'(stall_cnt), 32'h0);
    check("async_flush", 32'(flush_cnt), 32'h0);

    // Saturation: one BOOT cycle then 20 imem-wait cycles.
    drive_default();
    imem_ready = 1'b0;
    @(posedge stage_clk); #1;
    reset_n = 1'b1;
    repeat (10) begin @(posedge stage_clk); #1; end
    @(negedge stage_clk);
    check("imemwait_ena", 32'(stage_ena), 32'h1E);
    check("imemwait_x", 32'(stage_x), 32'h02);
    repeat (11) begin @(posedge stage_clk); #1; end
    imem_ready = 1'b1;
    @(negedge stage_clk);
    check("sat_stall16", 32'(stall_cnt), 32'd20);
    check("sat_stall4", 32'(stall4), 32'd15);
    check("sat_flush4", 32'(flush4), 32'd0);

    // Randomized run against the model.
    @(posedge stage_clk); #1;
    reset_n = 1'b0;
    @(posedge stage_clk); #1;
    model_reset();
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      imem_ready     = ($urandom_range(0, 99) < 85);
      dmem_req       = 1'($urandom_range(0, 1));
      dmem_ready     = ($urandom_range(0, 99) < 60);
      flush_pipeline = ($urandom_range(0, 99) < 8);
      ex_is_load     = ($urandom_range(0, 99) < 40);
      ex_rd          = 5'($urandom_range(0, 3));
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom_range(0, 1));
      id_use_rs2     = 1'($urandom_range(0, 1));
      @(negedge stage_clk);
      model_cycle(c);
      @(posedge stage_clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
